// File: rtl/rd_ddr3_unpack_pkg.sv
// Shared constants, output-stage state type and helpers for the DDR3 read-side unpacker.
package rd_ddr3_unpack_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 16;
  localparam int WORD_W = LANES * LANE_W;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } out_state_e;

  // Smallest r with 2**r >= depth.
  function automatic int log2_depth(input int unsigned depth);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Lane 0 is the most significant half-word.
  function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                 input logic [2:0]        lane);
    return word[(LANES - 1 - int'(lane)) * LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/rd_ddr3_unpack_buf.sv
// Single-clock circular buffer of 128-bit words with occupancy and full/empty flags.
module rd_ddr3_unpack_buf
  import rd_ddr3_unpack_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        wr_en_i,
  input  logic [WORD_W-1:0]           wr_data_i,
  input  logic                        rd_en_i,
  output logic [WORD_W-1:0]           rd_data_o,
  output logic [log2_depth(DEPTH):0]  count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int AW = log2_depth(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;
  logic              wr_ok;
  logic              rd_ok;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == {(AW + 1){1'b0}});
  assign wr_ok     = wr_en_i & ~full_o & ~clr_i;
  assign rd_ok     = rd_en_i & ~empty_o & ~clr_i;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage array, no reset: contents are only meaningful below the occupancy.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Next occupancy; a simultaneous write and read cancel out.
  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else if (clr_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_q <= rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rd_ddr3_unpack.sv
// DDR3 read-side buffer and 128-to-16 unpacker on ui_clk.
// Optional sticky overflow flag ovf_err when RD_UNPACK_OVF_FLAG_EN is defined.
module rd_ddr3_unpack
  import rd_ddr3_unpack_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int BURST_LEN = 32,
  parameter int CNT_W     = 9,
  parameter int BUSY_CYC  = 2
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              rd_addr_clr,
  input  logic              rd_fifo_wrreq,
  input  logic [WORD_W-1:0] rd_fifo_wrdata,
  output logic              rd_fifo_alfull,
  output logic [CNT_W-1:0]  rd_fifo_wr_cnt,
  output logic              rd_fifo_rst_busy,
  output logic [LANE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
`ifdef RD_UNPACK_OVF_FLAG_EN
  ,
  output logic              ovf_err
`endif
);

  localparam int AW     = log2_depth(DEPTH);
  localparam int BW_RAW = log2_depth(BUSY_CYC + 1);
  localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   BURST_C   = (AW + 1)'(BURST_LEN);
  localparam logic [BW-1:0] BUSY_INIT = BW'(BUSY_CYC);
  localparam logic [BW-1:0] BUSY_ONE  = BW'(1);
  localparam logic [2:0]    LAST_LANE = 3'(LANES - 1);
  localparam logic [2:0]    LANE_ONE  = 3'd1;

  logic [BW-1:0]     busy_cnt_q;
  logic              busy_q;
  out_state_e        state_q;
  logic [2:0]        lane_q;
  logic [WORD_W-1:0] word_q;
  logic [LANE_W-1:0] dout_q;
  logic              dout_valid_q;

  logic [WORD_W-1:0] buf_rd_data;
  logic [AW:0]       buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic              wr_en;
  logic              hs;
  logic              pop;
  logic [AW:0]       free_cnt;

  assign wr_en = rd_fifo_wrreq & ~busy_q & ~rd_addr_clr & ~buf_full;
  assign hs    = dout_valid_q & dout_ready;
  assign pop   = ~rd_addr_clr & ~buf_empty &
                 ((state_q == ST_EMPTY) | (hs & (lane_q == LAST_LANE)));

  rd_ddr3_unpack_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i     (ui_clk),
    .rst_i     (rst),
    .clr_i     (rd_addr_clr),
    .wr_en_i   (wr_en),
    .wr_data_i (rd_fifo_wrdata),
    .rd_en_i   (pop),
    .rd_data_o (buf_rd_data),
    .count_o   (buf_count),
    .full_o    (buf_full),
    .empty_o   (buf_empty)
  );

  assign free_cnt         = DEPTH_C - buf_count;
  assign rd_fifo_alfull   = (free_cnt < BURST_C);
  assign rd_fifo_wr_cnt   = CNT_W'(buf_count);
  assign rd_fifo_rst_busy = busy_q;
  assign dout             = dout_q;
  assign dout_valid       = dout_valid_q;

  // Busy window: reloaded by reset or flush, then counts down BUSY_CYC cycles.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      busy_cnt_q <= BUSY_INIT;
      busy_q     <= 1'b1;
    end else if (rd_addr_clr) begin
      busy_cnt_q <= BUSY_INIT;
      busy_q     <= 1'b1;
    end else if (busy_cnt_q != {BW{1'b0}}) begin
      busy_cnt_q <= busy_cnt_q - BUSY_ONE;
      busy_q     <= 1'b1;
    end else begin
      busy_cnt_q <= busy_cnt_q;
      busy_q     <= 1'b0;
    end
  end

  // Unpack stage: load a word on pop, then walk lanes MSB first on each handshake.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      lane_q       <= 3'd0;
      word_q       <= {WORD_W{1'b0}};
      dout_q       <= {LANE_W{1'b0}};
      dout_valid_q <= 1'b0;
    end else if (rd_addr_clr) begin
      state_q      <= ST_EMPTY;
      lane_q       <= 3'd0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (pop) begin
            state_q      <= ST_LOADED;
            lane_q       <= 3'd0;
            word_q       <= buf_rd_data;
            dout_q       <= lane_sel(buf_rd_data, 3'd0);
            dout_valid_q <= 1'b1;
          end
        end
        ST_LOADED: begin
          if (hs && lane_q != LAST_LANE) begin
            lane_q <= lane_q + LANE_ONE;
            dout_q <= lane_sel(word_q, lane_q + LANE_ONE);
          end else if (hs && pop) begin
            lane_q <= 3'd0;
            word_q <= buf_rd_data;
            dout_q <= lane_sel(buf_rd_data, 3'd0);
          end else if (hs) begin
            state_q      <= ST_EMPTY;
            lane_q       <= 3'd0;
            dout_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_EMPTY;
          lane_q       <= 3'd0;
          dout_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RD_UNPACK_OVF_FLAG_EN
  logic ovf_q;
  logic drop;

  assign drop    = rd_fifo_wrreq & ~busy_q & ~rd_addr_clr & buf_full;
  assign ovf_err = ovf_q;

  // Sticky record of any write lost to a full buffer.
  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (rd_addr_clr) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else begin
      ovf_q <= ovf_q;
    end
  end
`endif

endmodule

// File: tb/tb_rd_ddr3_unpack.sv
// Self-checking bench for rd_ddr3_unpack: expected half-word stream kept in a queue.
module tb_rd_ddr3_unpack;

  localparam int DEPTH = 64;

  logic         ui_clk = 1'b0;
  logic         rst;
  logic         rd_addr_clr;
  logic         rd_fifo_wrreq;
  logic [127:0] rd_fifo_wrdata;
  logic         rd_fifo_alfull;
  logic [8:0]   rd_fifo_wr_cnt;
  logic         rd_fifo_rst_busy;
  logic [15:0]  dout;
  logic         dout_valid;
  logic         dout_ready;
`ifdef RD_UNPACK_OVF_FLAG_EN
  logic         ovf_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  int words_written;
  logic [15:0] next_val;

  rd_ddr3_unpack dut (
    .ui_clk           (ui_clk),
    .rst              (rst),
    .rd_addr_clr      (rd_addr_clr),
    .rd_fifo_wrreq    (rd_fifo_wrreq),
    .rd_fifo_wrdata   (rd_fifo_wrdata),
    .rd_fifo_alfull   (rd_fifo_alfull),
    .rd_fifo_wr_cnt   (rd_fifo_wr_cnt),
    .rd_fifo_rst_busy (rd_fifo_rst_busy),
    .dout             (dout),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready)
`ifdef RD_UNPACK_OVF_FLAG_EN
    ,
    .ovf_err          (ovf_err)
`endif
  );

  always #5 ui_clk = ~ui_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Word whose lane i (lane 0 = MSB) carries base+i.
  task automatic put_word(input logic [15:0] base, input bit accept);
    logic [127:0] w;
    for (int i = 0; i < 8; i++) begin
      w[127 - 16*i -: 16] = base + 16'(i);
    end
    rd_fifo_wrreq  = 1'b1;
    rd_fifo_wrdata = w;
    if (accept) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(base + 16'(i));
    end
  endtask

  // One clock: score a pending handshake, advance, then check hold-while-stalled.
  task automatic tick();
    logic        hold_chk;
    logic [15:0] held;
    logic [15:0] e;
    hold_chk = dout_valid && !dout_ready && !rd_addr_clr && !rst;
    held = dout;
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'(dout_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stream", 32'(dout), 32'(e));
      end
    end
    @(negedge ui_clk);
    if (hold_chk) begin
      chk("hold_dout", 32'(dout), 32'(held));
      chk("hold_valid", 32'(dout_valid), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr_clr = 1'b0;
    rd_fifo_wrreq = 1'b0;
    rd_fifo_wrdata = 128'd0;
    dout_ready = 1'b0;

    // Reset and busy release.
    repeat (5) @(negedge ui_clk);
    chk("rst_busy", 32'(rd_fifo_rst_busy), 32'd1);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_cnt", 32'(rd_fifo_wr_cnt), 32'd0);
    chk("rst_alfull", 32'(rd_fifo_alfull), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
`ifdef RD_UNPACK_OVF_FLAG_EN
    chk("rst_ovf", 32'(ovf_err), 32'd0);
`endif
    rst = 1'b0;
    tick(); chk("busy_rel1", 32'(rd_fifo_rst_busy), 32'd1);
    tick(); chk("busy_rel2", 32'(rd_fifo_rst_busy), 32'd1);
    tick(); chk("busy_rel3", 32'(rd_fifo_rst_busy), 32'd0);
    chk("idle_valid", 32'(dout_valid), 32'd0);

    // Single word, latency and MSB-first lane order.
    dout_ready = 1'b1;
    rd_fifo_wrreq = 1'b1;
    rd_fifo_wrdata = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    for (int i = 7; i >= 0; i--) exp_q.push_back(16'(i));
    tick();
    chk("lat_valid_n1", 32'(dout_valid), 32'd0);
    chk("lat_cnt_n1", 32'(rd_fifo_wr_cnt), 32'd1);
    rd_fifo_wrreq = 1'b0;
    tick();
    chk("lat_valid_n2", 32'(dout_valid), 32'd1);
    chk("lat_dout_n2", 32'(dout), 32'h0007);
    chk("lat_cnt_n2", 32'(rd_fifo_wr_cnt), 32'd0);
    repeat (8) tick();
    chk("single_done_valid", 32'(dout_valid), 32'd0);
    chk("single_done_q", 32'(exp_q.size()), 32'd0);

    // Fill under full backpressure; occupancy excludes the output register.
    dout_ready = 1'b0;
    next_val = 16'd100;
    for (int k = 1; k <= 65; k++) begin
      int ec;
      put_word(next_val, 1'b1);
      next_val += 16'd8;
      tick();
      ec = (k == 1) ? 1 : k - 1;
      chk("fill_cnt", 32'(rd_fifo_wr_cnt), 32'(ec));
      chk("fill_alfull", 32'(rd_fifo_alfull), 32'((DEPTH - ec) < 32));
    end
    put_word(16'd9000, 1'b0);
    tick();
    chk("full_drop_cnt", 32'(rd_fifo_wr_cnt), 32'd64);
    chk("full_drop_alfull", 32'(rd_fifo_alfull), 32'd1);
    chk("full_dout", 32'(dout), 32'd100);
`ifdef RD_UNPACK_OVF_FLAG_EN
    chk("ovf_set", 32'(ovf_err), 32'd1);
`endif
    rd_fifo_wrreq = 1'b0;

    // Random backpressure until 1024 half-words (100..1123) have left.
    words_written = 65;
    for (int c = 0; c < 20000; c++) begin
      if (words_written >= 128 && exp_q.size() == 0) break;
      dout_ready = 1'($urandom_range(0, 1));
      if (words_written < 128 && exp_q.size() <= 8 * (DEPTH - 1) && $urandom_range(0, 1) == 1) begin
        put_word(next_val, 1'b1);
        next_val += 16'd8;
        words_written++;
      end else begin
        rd_fifo_wrreq = 1'b0;
      end
      tick();
    end
    rd_fifo_wrreq = 1'b0;
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_words", 32'(words_written), 32'd128);
    chk("rand_end_valid", 32'(dout_valid), 32'd0);
    chk("rand_end_cnt", 32'(rd_fifo_wr_cnt), 32'd0);

    // Flush mid-word at lane 3 with data still stored.
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      put_word(16'd5000 + 16'(8*k), 1'b1);
      tick();
    end
    rd_fifo_wrreq = 1'b0;
    dout_ready = 1'b1;
    repeat (3) tick();
    chk("pre_clr_cnt", 32'(rd_fifo_wr_cnt), 32'd3);
    chk("pre_clr_dout", 32'(dout), 32'd5003);
    rd_addr_clr = 1'b1;
    put_word(16'hBEEF, 1'b0);
    tick();
    exp_q.delete();
    chk("clr_valid", 32'(dout_valid), 32'd0);
    chk("clr_cnt", 32'(rd_fifo_wr_cnt), 32'd0);
    chk("clr_alfull", 32'(rd_fifo_alfull), 32'd0);
    chk("clr_busy0", 32'(rd_fifo_rst_busy), 32'd1);
`ifdef RD_UNPACK_OVF_FLAG_EN
    chk("clr_ovf", 32'(ovf_err), 32'd0);
`endif
    rd_addr_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_busy", 32'(rd_fifo_rst_busy), 32'(i < 2));
      chk("busy_wr_ignored", 32'(rd_fifo_wr_cnt), 32'd0);
    end
    rd_fifo_wrreq = 1'b0;
    tick();
    chk("post_clr_cnt", 32'(rd_fifo_wr_cnt), 32'd0);
    chk("post_clr_valid", 32'(dout_valid), 32'd0);

    // Write coinciding with the lane-7 pop at occupancy 10.
    dout_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      put_word(16'd6000 + 16'(8*k), 1'b1);
      tick();
    end
    rd_fifo_wrreq = 1'b0;
    chk("occ10", 32'(rd_fifo_wr_cnt), 32'd10);
    dout_ready = 1'b1;
    repeat (7) tick();
    chk("lane7_dout", 32'(dout), 32'd6007);
    chk("lane7_cnt", 32'(rd_fifo_wr_cnt), 32'd10);
    put_word(16'd6088, 1'b1);
    tick();
    rd_fifo_wrreq = 1'b0;
    chk("swap_cnt", 32'(rd_fifo_wr_cnt), 32'd10);
    chk("swap_dout", 32'(dout), 32'd6008);
    chk("swap_valid", 32'(dout_valid), 32'd1);
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("swap_drained", 32'(exp_q.size()), 32'd0);
    chk("swap_end_valid", 32'(dout_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
